// File: rtl/byte_write_pkg.sv
// rtl/byte_write_pkg.sv - shared types, lane/enable constants and lane placement helpers for byte_write_merger
package byte_write_pkg;

  typedef enum logic {
    EMPTY   = 1'b0,
    PARTIAL = 1'b1
  } merge_state_t;

  localparam logic LANE_LO = 1'b0;
  localparam logic LANE_HI = 1'b1;

  localparam logic [1:0] EN_NONE = 2'b00;
  localparam logic [1:0] EN_LO   = 2'b01;
  localparam logic [1:0] EN_HI   = 2'b10;
  localparam logic [1:0] EN_BOTH = 2'b11;

  // One-hot byte enable for a single byte written to the given lane
  function automatic logic [1:0] lane_en(input logic lane);
    return (lane == LANE_HI) ? EN_HI : EN_LO;
  endfunction

  // Place a byte into its lane of a 16-bit word, other lane zero
  function automatic logic [15:0] lane_word(input logic lane, input logic [7:0] data);
    return (lane == LANE_HI) ? {data, 8'h00} : {8'h00, data};
  endfunction

endpackage

// File: rtl/byte_write_merger_timer.sv
// rtl/byte_write_merger_timer.sv - idle counter that expires after TIMEOUT idle cycles (0 = never)
module byte_write_merger_timer #(
  parameter int TIMEOUT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic inc,
  output logic expire
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  logic [CW-1:0] cnt;

  // Count idle cycles; the owner clears on any non-idle cycle or on expiry, so it never wraps
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (inc && (TIMEOUT != 0)) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign expire = (TIMEOUT != 0) && (cnt == LAST);

endmodule

// File: rtl/byte_write_merger.sv
// rtl/byte_write_merger.sv - merges lane-tagged byte writes into 16-bit byte-enabled writes; optional BYTE_WRITE_MERGER_STATS_EN adds emit counters
module byte_write_merger
  import byte_write_pkg::*;
#(
  parameter int TIMEOUT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_val,
  input  logic        in_lane,
  input  logic [7:0]  in_byte,
  input  logic        flush,
`ifdef BYTE_WRITE_MERGER_STATS_EN
  output logic [7:0]  merged_cnt,
  output logic [7:0]  partial_cnt,
`endif
  output logic [1:0]  en,
  output logic [15:0] d
);

  merge_state_t state;
  logic         held_lane;
  logic [7:0]   held_byte;

  logic idle;
  logic expire;
  logic tmr_clear;
  logic tmr_inc;

  // Only an undisturbed PARTIAL cycle advances the idle count; everything else restarts it
  assign idle      = (state == PARTIAL) && !in_val && !flush;
  assign tmr_clear = !idle || expire;
  assign tmr_inc   = idle && !expire;

  byte_write_merger_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (tmr_clear),
    .inc    (tmr_inc),
    .expire (expire)
  );

  // Merge FSM with registered en/d: at most one emit per cycle, en/d zero when nothing leaves
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= EMPTY;
      held_lane <= LANE_LO;
      held_byte <= 8'h00;
      en        <= EN_NONE;
      d         <= 16'h0000;
    end else begin
      en <= EN_NONE;
      d  <= 16'h0000;
      case (state)
        EMPTY: begin
          if (in_val) begin
            if (flush) begin
              en <= lane_en(in_lane);
              d  <= lane_word(in_lane, in_byte);
            end else begin
              held_lane <= in_lane;
              held_byte <= in_byte;
              state     <= PARTIAL;
            end
          end
        end
        PARTIAL: begin
          if (in_val) begin
            if (in_lane != held_lane) begin
              en    <= EN_BOTH;
              d     <= lane_word(held_lane, held_byte) | lane_word(in_lane, in_byte);
              state <= EMPTY;
            end else begin
              // Lane conflict: old byte leaves alone, new byte takes its place even if flush is set
              en        <= lane_en(held_lane);
              d         <= lane_word(held_lane, held_byte);
              held_byte <= in_byte;
            end
          end else if (flush || expire) begin
            en    <= lane_en(held_lane);
            d     <= lane_word(held_lane, held_byte);
            state <= EMPTY;
          end
        end
      endcase
    end
  end

`ifdef BYTE_WRITE_MERGER_STATS_EN
  // Saturating tallies of full-word and single-byte emits, taken from the registered enables
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      merged_cnt  <= 8'h00;
      partial_cnt <= 8'h00;
    end else begin
      if ((en == EN_BOTH) && (merged_cnt != 8'hFF)) begin
        merged_cnt <= merged_cnt + 8'h01;
      end
      if (((en == EN_LO) || (en == EN_HI)) && (partial_cnt != 8'hFF)) begin
        partial_cnt <= partial_cnt + 8'h01;
      end
    end
  end
`endif

endmodule

// File: tb/tb_byte_write_merger.sv
// tb/tb_byte_write_merger.sv - self-checking bench for byte_write_merger with a queue-based reference model
module tb_byte_write_merger;

  localparam int TIMEOUT = 4;

  logic        clk;
  logic        reset;
  logic        in_val;
  logic        in_lane;
  logic [7:0]  in_byte;
  logic        flush;
  logic [1:0]  en;
  logic [15:0] d;
`ifdef BYTE_WRITE_MERGER_STATS_EN
  logic [7:0]  merged_cnt;
  logic [7:0]  partial_cnt;
`endif

  byte_write_merger #(
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_val      (in_val),
    .in_lane     (in_lane),
    .in_byte     (in_byte),
    .flush       (flush),
`ifdef BYTE_WRITE_MERGER_STATS_EN
    .merged_cnt  (merged_cnt),
    .partial_cnt (partial_cnt),
`endif
    .en          (en),
    .d           (d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream byte-enabled register stage fed by the merger
  logic [15:0] q;
  always @(posedge clk) begin
    if (en[0]) q[7:0]  <= d[7:0];
    if (en[1]) q[15:8] <= d[15:8];
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, want, $time);
    end
  endtask

  // Reference model: pending bytes as a queue of {lane, byte}, plus idle cycles seen while holding
  logic [8:0]  pend_q[$];
  int          idle_cycles;
  logic [1:0]  exp_en;
  logic [15:0] exp_d;
  logic [1:0]  prev_en;
  logic [15:0] prev_d;
  logic [15:0] q_gold;

  function automatic void emit_byte(input logic lane, input logic [7:0] b);
    exp_en[lane] = 1'b1;
    if (lane) exp_d[15:8] = b;
    else      exp_d[7:0]  = b;
  endfunction

  function automatic void model(input logic v, input logic l, input logic [7:0] b, input logic f);
    logic [8:0] h;
    exp_en = 2'b00;
    exp_d  = 16'h0000;
    if (v) begin
      idle_cycles = 0;
      if (pend_q.size() == 0) begin
        if (f) emit_byte(l, b);
        else   pend_q.push_back({l, b});
      end else begin
        h = pend_q.pop_front();
        emit_byte(h[8], h[7:0]);
        if (h[8] != l) emit_byte(l, b);
        else           pend_q.push_back({l, b});
      end
    end else if (pend_q.size() != 0) begin
      if (f) begin
        h = pend_q.pop_front();
        emit_byte(h[8], h[7:0]);
        idle_cycles = 0;
      end else begin
        idle_cycles++;
        if (TIMEOUT != 0 && idle_cycles == TIMEOUT) begin
          h = pend_q.pop_front();
          emit_byte(h[8], h[7:0]);
          idle_cycles = 0;
        end
      end
    end
  endfunction

  task automatic step(input logic v, input logic l, input logic [7:0] b, input logic f);
    in_val  = v;
    in_lane = l;
    in_byte = b;
    flush   = f;
    model(v, l, b, f);
    @(posedge clk);
    if (prev_en[0]) q_gold[7:0]  = prev_d[7:0];
    if (prev_en[1]) q_gold[15:8] = prev_d[15:8];
    prev_en = exp_en;
    prev_d  = exp_d;
    @(negedge clk);
    check("en", {30'd0, en}, {30'd0, exp_en});
    check("d", {16'd0, d}, {16'd0, exp_d});
    check("q", {16'd0, q}, {16'd0, q_gold});
  endtask

  initial begin
    idle_cycles = 0;
    prev_en = 2'b00;
    prev_d  = 16'h0000;
    q_gold  = 16'h0000;
    q       = 16'h0000;
    in_val = 1'b0; in_lane = 1'b0; in_byte = 8'h00; flush = 1'b0;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_en", {30'd0, en}, 32'd0);
    check("reset_d", {16'd0, d}, 32'd0);
    reset = 1'b1;

    // Pair merge
    step(1'b1, 1'b0, 8'h01, 1'b0);
    check("pair_first_en", {30'd0, en}, 32'd0);
    step(1'b1, 1'b1, 8'h02, 1'b0);
    check("pair_en", {30'd0, en}, 32'h3);
    check("pair_d", {16'd0, d}, 32'h0201);

    // Conflict
    step(1'b1, 1'b0, 8'h67, 1'b0);
    step(1'b1, 1'b0, 8'hAB, 1'b0);
    check("conf_en", {30'd0, en}, 32'h1);
    check("conf_d", {16'd0, d}, 32'h0067);
    step(1'b1, 1'b1, 8'hCD, 1'b0);
    check("conf_merge_d", {16'd0, d}, 32'hCDAB);

    // Timeout: emit exactly TIMEOUT edges after acceptance
    step(1'b1, 1'b1, 8'h45, 1'b0);
    for (int i = 1; i <= TIMEOUT + 2; i++) begin
      step(1'b0, 1'b0, 8'h00, 1'b0);
      if (i == TIMEOUT) begin
        check("tmo_en", {30'd0, en}, 32'h2);
        check("tmo_d", {16'd0, d}, 32'h4500);
      end else begin
        check("tmo_quiet", {30'd0, en}, 32'h0);
      end
    end

    // Flush
    step(1'b1, 1'b1, 8'h89, 1'b1);
    check("flush_empty_d", {16'd0, d}, 32'h8900);
    step(1'b1, 1'b0, 8'hEF, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    check("flush_held_en", {30'd0, en}, 32'h1);
    check("flush_held_d", {16'd0, d}, 32'h00EF);

    // Reset mid-cycle while an emit is showing and a byte is held
    step(1'b1, 1'b0, 8'h11, 1'b0);
    step(1'b1, 1'b0, 8'h33, 1'b0);
    check("pre_reset_en", {30'd0, en}, 32'h1);
    #2 reset = 1'b0;
    #1;
    check("async_reset_en", {30'd0, en}, 32'd0);
    check("async_reset_d", {16'd0, d}, 32'd0);
    pend_q.delete();
    idle_cycles = 0;
    prev_en = 2'b00;
    prev_d  = 16'h0000;
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < TIMEOUT + 3; i++) begin
      step(1'b0, 1'b0, 8'h00, 1'b0);
      check("post_reset_quiet", {30'd0, en}, 32'd0);
    end

    // Random traffic, idle-biased so timeouts also occur
    for (int i = 0; i < 200; i++) begin
      step(($urandom_range(0, 9) < 6), 1'($urandom), 8'($urandom), ($urandom_range(0, 7) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
